// File: rtl/uart_rx_cfg.sv
// Runtime-configurable oversampling UART receiver feeding an error-tagged RX FIFO with sticky status.
// Latency: entry pushed at mid-sample of the last stop bit, visible on v_o one cycle later.
// Backpressure: none toward the line; a full FIFO without a same-cycle pop drops the frame and sets overflow_o.
module uart_rx_cfg #(
  parameter int os_p            = 16,
  parameter int max_data_bits_p = 9,
  parameter int div_width_p     = 16,
  parameter int fifo_els_p      = 16,
  parameter int sync_stages_p   = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               cfg_en_i,
  input  logic [div_width_p-1:0]             cfg_div_i,
  input  logic [3:0]                         cfg_data_bits_i,
  input  logic [1:0]                         cfg_parity_i,
  input  logic                               cfg_stop2_i,
  input  logic                               rx_i,
  output logic                               v_o,
  output logic [max_data_bits_p-1:0]         data_o,
  output logic                               data_frame_err_o,
  output logic                               data_parity_err_o,
  input  logic                               yumi_i,
  output logic [$clog2(fifo_els_p+1)-1:0]    count_o,
  input  logic                               clr_err_i,
  output logic                               overflow_o,
  output logic                               frame_err_o,
  output logic                               parity_err_o,
  output logic                               break_o
);

  localparam int os_w  = $clog2(os_p);
  localparam int ptr_w = $clog2(fifo_els_p);
  localparam int cnt_w = $clog2(fifo_els_p+1);
  localparam int ent_w = max_data_bits_p + 2;
  localparam logic [os_w-1:0] os_a    = os_w'(os_p/2 - 1);
  localparam logic [os_w-1:0] os_b    = os_w'(os_p/2);
  localparam logic [os_w-1:0] os_c    = os_w'(os_p/2 + 1);
  localparam logic [os_w-1:0] os_last = os_w'(os_p - 1);
  localparam logic [3:0]      nb_min  = 4'd5;
  localparam logic [3:0]      nb_max  = 4'(max_data_bits_p);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;

  state_e                     state_q, state_n;
  logic [1:0]                 rst_sync_q;
  logic                       rst_n;
  logic [sync_stages_p-1:0]   sync_q;
  logic                       rx_s;
  logic [div_width_p-1:0]     div_q, div_cnt_q, div_m1;
  logic [os_w-1:0]            os_cnt_q;
  logic                       v0_q, v1_q;
  logic                       tick, mid, sample;
  logic [3:0]                 nb_q, nb_clamp, bit_idx_q;
  logic                       par_en_q, par_odd_q, stop2_q, stop_idx_q;
  logic [max_data_bits_p-1:0] data_q;
  logic                       ferr_q, perr_q, par_bit_q, fe_now, brk_cond;
  logic                       start_det, push_req, brk_set;
  logic [ent_w-1:0]           mem_q [fifo_els_p];
  logic [ent_w-1:0]           head;
  logic [ptr_w-1:0]           wr_ptr_q, rd_ptr_q;
  logic [cnt_w-1:0]           count_q;
  logic                       full, pop, push;
  logic                       overflow_q, frame_err_q, parity_err_q, break_q;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Synchronize the async line; idle-high so reset does not look like a start bit.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[sync_stages_p-2:0], rx_i};
  end
  assign rx_s = sync_q[sync_stages_p-1];

  assign div_m1   = (div_q == '0) ? '0 : div_q - div_width_p'(1);
  assign tick     = (div_cnt_q >= div_m1);
  assign mid      = tick && (os_cnt_q == os_c);
  assign sample   = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);
  assign brk_cond = (data_q == '0) && (!par_en_q || !par_bit_q);
  assign fe_now   = ferr_q | ~sample;

  // Clamp the programmed data width into the supported range.
  always_comb begin
    nb_clamp = cfg_data_bits_i;
    if (cfg_data_bits_i < nb_min)      nb_clamp = nb_min;
    else if (cfg_data_bits_i > nb_max) nb_clamp = nb_max;
  end

  // Tick divider, position within the bit, and the two early majority votes.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      os_cnt_q  <= '0;
      v0_q      <= 1'b1;
      v1_q      <= 1'b1;
    end else begin
      if (start_det || brk_set || (state_q == BREAK && !rx_s)) begin
        div_cnt_q <= '0;
        os_cnt_q  <= '0;
      end else if (tick) begin
        div_cnt_q <= '0;
        os_cnt_q  <= (os_cnt_q == os_last) ? '0 : os_cnt_q + os_w'(1);
      end else begin
        div_cnt_q <= div_cnt_q + div_width_p'(1);
      end
      if (tick && os_cnt_q == os_a) v0_q <= rx_s;
      if (tick && os_cnt_q == os_b) v1_q <= rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // FSM next state and per-frame strobes; disabling the receiver aborts any frame.
  always_comb begin
    state_n   = state_q;
    start_det = 1'b0;
    push_req  = 1'b0;
    brk_set   = 1'b0;
    case (state_q)
      IDLE:   if (cfg_en_i && !rx_s) begin
                start_det = 1'b1;
                state_n   = START;
              end
      START:  if (mid) state_n = sample ? IDLE : DATA;
      DATA:   if (mid && bit_idx_q == nb_q - 4'd1) state_n = par_en_q ? PARITY : STOP;
      PARITY: if (mid) state_n = STOP;
      STOP:   if (mid) begin
                if (!stop_idx_q && !sample && brk_cond) begin
                  brk_set = 1'b1;
                  state_n = BREAK;
                end else if (stop_idx_q == stop2_q) begin
                  push_req = 1'b1;
                  state_n  = IDLE;
                end
              end
      BREAK:  if (tick && rx_s && os_cnt_q == os_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!cfg_en_i) begin
      state_n   = IDLE;
      start_det = 1'b0;
      push_req  = 1'b0;
      brk_set   = 1'b0;
    end
  end

  // Frame datapath: latch config at start, then collect data, parity and stop results.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      nb_q       <= nb_min;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      par_bit_q  <= 1'b0;
    end else if (start_det) begin
      div_q      <= cfg_div_i;
      nb_q       <= nb_clamp;
      par_en_q   <= (cfg_parity_i == 2'b01) || (cfg_parity_i == 2'b10);
      par_odd_q  <= (cfg_parity_i == 2'b10);
      stop2_q    <= cfg_stop2_i;
      data_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      par_bit_q  <= 1'b0;
    end else if (mid) begin
      case (state_q)
        DATA: begin
          for (int i = 0; i < max_data_bits_p; i++)
            if (bit_idx_q == 4'(i)) data_q[i] <= sample;
          bit_idx_q <= bit_idx_q + 4'd1;
        end
        PARITY: begin
          perr_q    <= ((^data_q) ^ sample) != par_odd_q;
          par_bit_q <= sample;
        end
        STOP: begin
          ferr_q     <= fe_now;
          stop_idx_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pop  = yumi_i && (count_q != '0);
  assign full = (count_q == cnt_w'(fifo_els_p));
  assign push = push_req && (!full || pop);

  // FIFO storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {perr_q, fe_now, data_q};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ptr_w'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ptr_w'(1);
      if (push && !pop)      count_q <= count_q + cnt_w'(1);
      else if (pop && !push) count_q <= count_q - cnt_w'(1);
    end
  end

  // Sticky status; a new event in the same cycle as a clear wins.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      overflow_q   <= (push_req && full && !pop) | (overflow_q   & ~clr_err_i);
      frame_err_q  <= (push_req && fe_now)       | (frame_err_q  & ~clr_err_i);
      parity_err_q <= (push_req && perr_q)       | (parity_err_q & ~clr_err_i);
      break_q      <= brk_set                    | (break_q      & ~clr_err_i);
    end
  end

  assign head              = mem_q[rd_ptr_q];
  assign v_o               = (count_q != '0);
  assign data_o            = v_o ? head[max_data_bits_p-1:0] : '0;
  assign data_frame_err_o  = v_o & head[max_data_bits_p];
  assign data_parity_err_o = v_o & head[max_data_bits_p+1];
  assign count_o           = count_q;
  assign overflow_o        = overflow_q;
  assign frame_err_o       = frame_err_q;
  assign parity_err_o      = parity_err_q;
  assign break_o           = break_q;

endmodule
